sync_generator: RTL
===================

SYNC_GENERATOR -- requirements
Module: sync_generator

Interface
REQ-001 The block SHALL have parameter PERIOD, default 3200, meaning line period in clock cycles (64 us at 50 MHz); legal range PULSE+2..4095.
REQ-002 The block SHALL have parameter PULSE, default 235, meaning sync pulse width in clock cycles (4.7 us); legal range 1..PERIOD-2.
REQ-003 The block SHALL have parameter LINES, default 625, meaning lines per frame; legal range 2..1023.
REQ-004 The block SHALL have port clk_50mhz_in, input, width 1: the single clock, 50 MHz; all logic runs on its rising edge.
REQ-005 The block SHALL have port rst_n_in, input, width 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port enable_in, input, width 1: requests sync generation.
REQ-007 The block SHALL have port positive_polarity_in, input, width 1: 1 means active-high sync pulses, 0 means active-low.
REQ-008 The block SHALL have port sync_out, output, width 1: registered composite line sync.
REQ-009 The block SHALL have port line_start_out, output, width 1: one-cycle strobe on the first cycle of each pulse.
REQ-010 The block SHALL have port active_polarity_out, output, width 1: the polarity currently applied to sync_out.
REQ-011 The block SHALL have port line_cnt_out, output, width 10: current line index.
REQ-012 The block SHALL have port frame_start_out, output, width 1: one-cycle strobe when line 0 starts.

Function
REQ-013 The block SHALL implement states IDLE, PULSE and GAP, with a 12-bit cycle counter cnt and a polarity register pol.
REQ-014 In IDLE, sync_out SHALL equal ~pol (the inactive level) and cnt SHALL hold 0.
REQ-015 When enable_in=1 at an edge in IDLE, the block SHALL enter PULSE with cnt=0, pol<=positive_polarity_in and line_start_out=1, so that sync_out is active one cycle after enable is sampled.
REQ-016 In PULSE, sync_out SHALL equal pol for cnt 0..PULSE-1, and at cnt=PULSE-1 the block SHALL go to GAP.
REQ-017 In GAP, sync_out SHALL equal ~pol for cnt PULSE..PERIOD-1.
REQ-018 At cnt=PERIOD-1, the block SHALL enter PULSE (cnt=0, re-latch pol, strobe line_start_out) if enable_in=1, else enter IDLE.
REQ-019 The block SHALL sample enable_in and positive_polarity_in only at a line boundary or in IDLE, so that mid-line changes never truncate or glitch a pulse.
REQ-020 When the polarity changes at a boundary, sync_out SHALL switch directly from old-inactive to new-active level in one edge, with no extra toggles.
REQ-021 The block SHALL assert line_start_out for exactly one cycle per line, and only in the first PULSE cycle.
REQ-022 active_polarity_out SHALL equal pol at all times.
REQ-023 The block SHALL produce the period exactly PERIOD cycles and the pulse exactly PULSE cycles, with no off-by-one on re-entry.

Reset
REQ-024 While rst_n_in=0, the block SHALL force state=IDLE, cnt=0, pol=0, sync_out=1, line_start_out=0, active_polarity_out=0, line_cnt_out=0 and frame_start_out=0.
REQ-025 A reset asserted mid-pulse SHALL return sync_out to 1 immediately (asynchronously), and the first line after release SHALL start per REQ-015.

Configuration
REQ-026 The macro SYNC_GEN_LINE_COUNT_EN SHALL control line counting.
REQ-027 When SYNC_GEN_LINE_COUNT_EN is defined, line_cnt_out SHALL go to 0 on IDLE->PULSE, increment on each GAP->PULSE transition, and wrap from LINES-1 to 0; it SHALL hold its value in IDLE.
REQ-028 When SYNC_GEN_LINE_COUNT_EN is defined, frame_start_out SHALL equal line_start_out whenever the line entered is 0.
REQ-029 When SYNC_GEN_LINE_COUNT_EN is undefined, line_cnt_out and frame_start_out SHALL still exist but be tied to constant 0, with no counter logic present.

Verification (PERIOD=10, PULSE=3, LINES=4)
REQ-030 The bench SHALL check: reset released, enable=1, polarity=0 -> sync_out low for 3 cycles, high for 7, repeating every 10 cycles; line_start_out high 1 cycle per line.
REQ-031 The bench SHALL check: polarity toggled to 1 at cnt=1 -> the current pulse stays low for the full 3 cycles; the next line is a high pulse; active_polarity_out changes at that line start.
REQ-032 The bench SHALL check: enable dropped at cnt=5 -> the line completes to cnt=9, then IDLE with sync_out at the inactive level and no further line_start_out.
REQ-033 The bench SHALL check: rst_n_in low at cnt=1 of a pulse -> sync_out=1 asynchronously and all outputs at reset values.
REQ-034 The bench SHALL check: with SYNC_GEN_LINE_COUNT_EN defined, 9 lines generated -> line_cnt_out sequence 0,1,2,3,0,1,2,3,0 and frame_start_out on lines 1, 5 and 9; without the macro, both outputs stay 0.

Source files
------------

// File: rtl/sync_generator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sync_generator
//
// Purpose: composite line-sync generator. Each line is PERIOD clock cycles
// long and starts with a PULSE-cycle sync pulse at the active level, followed
// by a gap at the inactive level. Enable and polarity are only sampled at a
// line boundary (or while idle), so a running line is never truncated or
// glitched by mid-line input changes.
//
// Optional feature: define SYNC_GEN_LINE_COUNT_EN to enable the line counter
// (line_cnt_out / frame_start_out). When undefined both outputs are tied to 0.
//
// Parameters:
//   PERIOD  line period in clock cycles   (PULSE+2 .. 4095)
//   PULSE   sync pulse width in cycles    (1 .. PERIOD-2)
//   LINES   lines per frame               (2 .. 1023)
//
// Ports:
//   clk_50mhz_in          in   single clock, rising edge
//   rst_n_in              in   asynchronous active-low reset
//   enable_in             in   request sync generation
//   positive_polarity_in  in   1 = active-high pulses, 0 = active-low
//   sync_out              out  registered composite line sync
//   line_start_out        out  one-cycle strobe on first pulse cycle of a line
//   active_polarity_out   out  polarity currently applied to sync_out
//   line_cnt_out[9:0]     out  current line index
//   frame_start_out       out  one-cycle strobe when line 0 starts
// -----------------------------------------------------------------------------
module sync_generator #(
  parameter int unsigned PERIOD = 3200,
  parameter int unsigned PULSE  = 235,
  parameter int unsigned LINES  = 625
) (
  input  logic       clk_50mhz_in,
  input  logic       rst_n_in,
  input  logic       enable_in,
  input  logic       positive_polarity_in,
  output logic       sync_out,
  output logic       line_start_out,
  output logic       active_polarity_out,
  output logic [9:0] line_cnt_out,
  output logic       frame_start_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [11:0] PULSE_LAST  = 12'(PULSE - 1);
  localparam logic [11:0] PERIOD_LAST = 12'(PERIOD - 1);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        pol_q, pol_d;
  logic        sync_q, sync_d;
  logic        line_start_q, line_start_d;
  logic        start_line;

  // Next-state logic. A new line is started from IDLE or from the last GAP
  // cycle; that is the only place the inputs are looked at.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pol_d      = pol_q;
    start_line = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 12'd0;
        if (enable_in) begin
          start_line = 1'b1;
        end
      end
      ST_PULSE: begin
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == PERIOD_LAST) begin
          cnt_d = 12'd0;
          if (enable_in) begin
            start_line = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 12'd0;
      end
    endcase

    if (start_line) begin
      state_d = ST_PULSE;
      cnt_d   = 12'd0;
      pol_d   = positive_polarity_in;
    end

    // Output level is derived from the *next* state and polarity so that a
    // polarity change at a boundary goes straight from old-inactive to
    // new-active in a single registered step.
    sync_d       = (state_d == ST_PULSE) ? pol_d : ~pol_d;
    line_start_d = start_line;
  end

  always_ff @(posedge clk_50mhz_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 12'd0;
      pol_q        <= 1'b0;
      sync_q       <= 1'b1;
      line_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pol_q        <= pol_d;
      sync_q       <= sync_d;
      line_start_q <= line_start_d;
    end
  end

  assign sync_out            = sync_q;
  assign line_start_out      = line_start_q;
  assign active_polarity_out = pol_q;

`ifdef SYNC_GEN_LINE_COUNT_EN
  localparam logic [9:0] LINE_LAST = 10'(LINES - 1);

  logic [9:0] line_q, line_d;
  logic       frame_start_q, frame_start_d;

  // Leaving IDLE always restarts the frame at line 0; a back-to-back line
  // advances and wraps at LINES-1.
  always_comb begin
    line_d = line_q;
    if (start_line) begin
      if (state_q == ST_IDLE || line_q == LINE_LAST) begin
        line_d = 10'd0;
      end else begin
        line_d = line_q + 10'd1;
      end
    end
    frame_start_d = start_line && (line_d == 10'd0);
  end

  always_ff @(posedge clk_50mhz_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      line_q        <= 10'd0;
      frame_start_q <= 1'b0;
    end else begin
      line_q        <= line_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign line_cnt_out    = line_q;
  assign frame_start_out = frame_start_q;
`else
  assign line_cnt_out    = 10'd0;
  assign frame_start_out = 1'b0;
`endif

endmodule
